miriscv_fetch_unit: RTL and testbench
=====================================

// Module: miriscv_fetch_unit
// PURPOSE
// - Instruction fetch stage directly upstream of the decoder: issues word fetches on the instruction
//   bus, buffers returned words with their PC, presents {instr, pc} to decode over valid/ready.
// - Handles control-flow redirects (branch/jal/jalr/trap): flushes buffered words, discards in-flight responses.
// PARAMETERS
// - RESET_PC     32'h0000_0000  PC of first fetch after reset
// - FIFO_DEPTH   2              fetch buffer entries (power of 2, >=2); also max outstanding requests
// PORTS
// - clk_i              in   1   clock, all state on rising edge
// - rst_i              in   1   asynchronous active-high reset
// - instr_req_o        out  1   bus request
// - instr_addr_o       out  32  word address of request, [1:0]==2'b00
// - instr_gnt_i        in   1   request accepted this cycle
// - instr_rvalid_i     in   1   response valid (in-order, >=1 cycle after gnt)
// - instr_rdata_i      in   32  response instruction word
// - redirect_i         in   1   control-flow change, single-cycle pulse
// - redirect_pc_i      in   32  new PC; bits [1:0] ignored (forced 0)
// - fetch_valid_o      out  1   {fetch_instr_o, fetch_pc_o} valid to decode
// - fetch_instr_o      out  32  instruction word (decoder input)
// - fetch_pc_o         out  32  PC of fetch_instr_o
// - fetch_ready_i      in   1   decode accepts; transfer = valid & ready
// - fetch_busy_o       out  1   requests outstanding or buffer non-empty
// BEHAVIOUR
// - Reset: instr_req_o=0, instr_addr_o=RESET_PC, fetch_valid_o=0, fetch_instr_o=0, fetch_pc_o=0,
//   fetch_busy_o=0; FSM=S_BOOT, req_pc=RESET_PC, outstanding=0, discard=0, FIFO empty.
// - FSM: S_BOOT -> S_RUN on first cycle after reset release (no request in S_BOOT).
//   S_RUN: redirect_i with outstanding>0 (incl. a granted-this-cycle request) -> S_DRAIN, discard=outstanding;
//          with outstanding==0 -> stay S_RUN.
//   S_DRAIN: no new requests; each rvalid decrements discard, data dropped; discard reaching 0 -> S_RUN.
//   A further redirect_i in S_DRAIN only reloads req_pc; discard keeps counting.
// - Credit rule: instr_req_o=1 in S_RUN when outstanding + fifo_count < FIFO_DEPTH, evaluated on
//   registered counts (no combinational path from fetch_ready_i or instr_rvalid_i to instr_req_o).
// - Once asserted, instr_req_o and instr_addr_o are held stable until instr_gnt_i, even across redirect_i;
//   a request granted after redirect is counted into discard and its response dropped.
// - On gnt: req_pc += 4 (32-bit wrap 32'hFFFF_FFFC -> 0), push req_pc into PC tag queue, outstanding++.
// - On rvalid (not discarding): push {rdata, tag_pc} into FIFO, pop tag queue, outstanding--.
// - gnt and rvalid in same cycle: outstanding unchanged; tag queue push and pop both occur.
// - Latency: rvalid in cycle N -> fetch_valid_o in N+1 (registered FIFO output, no bypass).
// - FIFO pop on fetch_valid_o & fetch_ready_i; push and pop same cycle allowed when full.
// - fetch_instr_o/fetch_pc_o stable while fetch_valid_o & !fetch_ready_i.
// - redirect_i: FIFO and tag queue cleared next cycle; fetch_valid_o=0 in the cycle after redirect_i;
//   req_pc=redirect_pc_i & ~3. redirect_i has priority over any same-cycle push.
// - Same-cycle fetch_ready_i and redirect_i: the presented word counts as consumed by decode.
// - rvalid while outstanding==0: ignored (protocol violation; SVA flags it).
// - fetch_busy_o = (outstanding != 0) | (fifo_count != 0) | (state == S_DRAIN).
// - Reset mid-operation: all state returns to reset values immediately; pending bus responses not tracked.
// STRUCTURE
// - Shared package miriscv_fetch_pkg: fetch_state_e {S_BOOT, S_RUN, S_DRAIN};
//   fetch_entry_t struct {logic [31:0] instr; logic [31:0] pc}; constant ILEN = 32.
// - Sub-module miriscv_fetch_fifo: generic sync FIFO (DEPTH, WIDTH), flush_i, push/pop, full/empty,
//   count; instantiated twice: entry FIFO (fetch_entry_t) and PC tag queue (32 bit).
// - Top: FSM, req_pc register, outstanding/discard counters ($clog2(FIFO_DEPTH)+1 bits), credit logic.
// TESTING
// - Boot: release rst_i, gnt=1, rvalid 1 cycle later -> addr 0x0,0x4,0x8; fetch_pc_o 0x0 then 0x4, in order.
// - Backpressure: fetch_ready_i=0 for 10 cycles -> exactly FIFO_DEPTH grants, instr_req_o then 0; outputs stable.
// - Redirect with 2 outstanding to 0x100 -> both responses dropped, next addr 0x100, first fetch_pc_o 0x100.
// - Ungranted request at 0x8 when redirect_i to 0x40 -> addr stays 0x8 until gnt, response dropped, then 0x40.
// - Wrap: RESET_PC=32'hFFFF_FFF8 -> addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
// - Async reset asserted mid-stream with 2 outstanding -> instr_req_o, fetch_valid_o 0 same cycle; restart at RESET_PC.

Source files
------------

// File: rtl/miriscv_fetch_pkg.sv
// Shared types for the miriscv instruction fetch stage.
//   fetch_state_e : fetch control FSM encoding
//   fetch_entry_t : one buffered fetch result {instr, pc}
//   ILEN          : instruction word width
package miriscv_fetch_pkg;

  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [ILEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/miriscv_fetch_fifo.sv
// Generic synchronous FIFO with registered storage and synchronous flush.
//   clk_i, rst_i     : clock, async active-high reset
//   flush_i          : empty the FIFO (wins over a same-cycle push)
//   push_i, data_i   : write side; a push into a full FIFO is taken only
//                      when a pop happens in the same cycle
//   pop_i, data_o    : read side; data_o is the head entry, read from flops
//   full_o, empty_o  : occupancy flags
//   count_o          : number of entries held
module miriscv_fetch_fifo
  import miriscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wptr_q, rptr_q;
  logic [AW:0]                 count_q;
  logic                        do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/miriscv_fetch_unit.sv
// Instruction fetch stage feeding the decoder.
// Issues word fetches on the instruction bus, tags each grant with its PC,
// buffers responses as {instr, pc} and presents them over valid/ready.
// Redirects flush buffered words and drop responses still in flight.
//   clk_i, rst_i                  : clock, async active-high reset
//   instr_req_o/addr_o/gnt_i      : bus request channel
//   instr_rvalid_i/rdata_i        : in-order bus response channel
//   redirect_i, redirect_pc_i     : control-flow change pulse and target
//   fetch_valid_o/instr_o/pc_o    : output to decode
//   fetch_ready_i                 : decode accepts the presented word
//   fetch_busy_o                  : work in flight or buffered
module miriscv_fetch_unit
  import miriscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  input  logic        fetch_ready_i,
  output logic        fetch_busy_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] discard_q, discard_d;
  // A request raised but not yet granted is frozen here; stale marks one
  // whose stream was abandoned by a redirect, so its response must be dropped.
  logic          hold_q, hold_d;
  logic [31:0]   hold_addr_q;
  logic          stale_q, stale_d;

  logic          gnt_fire, rv_ok, rv_keep, credit;
  logic          ent_full, ent_empty, tag_full, tag_empty;
  logic [CW-1:0] ent_cnt, tag_cnt;
  logic [31:0]   tag_pc;
  fetch_entry_t  ent_in, ent_out;

  // Credit uses registered counts only, so no response/ready path reaches instr_req_o.
  assign credit      = ({1'b0, out_q} + {1'b0, ent_cnt}) < (CW+1)'(FIFO_DEPTH);
  assign instr_req_o = hold_q | ((state_q == S_RUN) & credit);
  assign instr_addr_o = hold_q ? hold_addr_q : req_pc_q;

  assign gnt_fire = instr_req_o & instr_gnt_i;
  assign rv_ok    = instr_rvalid_i & (out_q != '0);
  assign rv_keep  = rv_ok & (discard_q == '0);
  assign out_d    = out_q + CW'(gnt_fire) - CW'(rv_ok);

  assign hold_d  = instr_req_o & ~instr_gnt_i;
  assign stale_d = hold_d & (stale_q | redirect_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      // A grant of a stale request also has to be drained.
      S_RUN:   if ((redirect_i | (stale_q & gnt_fire)) && (out_d != '0)) state_d = S_DRAIN;
      S_DRAIN: if (out_d == '0) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  // Everything in flight while draining belongs to an abandoned stream.
  assign discard_d = (state_d == S_DRAIN) ? out_d : '0;

  always_comb begin
    req_pc_d = req_pc_q;
    if (redirect_i)                req_pc_d = redirect_pc_i & ~32'd3;
    else if (gnt_fire && !stale_q) req_pc_d = req_pc_q + 32'd4;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_BOOT;
      req_pc_q    <= RESET_PC;
      out_q       <= '0;
      discard_q   <= '0;
      hold_q      <= 1'b0;
      hold_addr_q <= RESET_PC;
      stale_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_pc_q    <= req_pc_d;
      out_q       <= out_d;
      discard_q   <= discard_d;
      hold_q      <= hold_d;
      hold_addr_q <= instr_addr_o;
      stale_q     <= stale_d;
    end
  end

  // PC tag queue: one entry per live (non-stale) outstanding request.
  miriscv_fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tag_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (gnt_fire & ~stale_q),
    .data_i  (instr_addr_o),
    .pop_i   (rv_keep),
    .data_o  (tag_pc),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_cnt)
  );

  assign ent_in = '{instr: instr_rdata_i, pc: tag_pc};

  miriscv_fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_ent_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (rv_keep),
    .data_i  (ent_in),
    .pop_i   (fetch_valid_o & fetch_ready_i),
    .data_o  (ent_out),
    .full_o  (ent_full),
    .empty_o (ent_empty),
    .count_o (ent_cnt)
  );

  assign fetch_valid_o = ~ent_empty;
  assign fetch_instr_o = ent_out.instr;
  assign fetch_pc_o    = ent_out.pc;
  assign fetch_busy_o  = (out_q != '0) | (ent_cnt != '0) | (state_q == S_DRAIN);

  a_rvalid_tracked: assert property (@(posedge clk_i) disable iff (rst_i)
    instr_rvalid_i |-> (out_q != '0));
  a_tag_avail: assert property (@(posedge clk_i) disable iff (rst_i)
    rv_keep |-> !tag_empty);
  a_tag_room: assert property (@(posedge clk_i) disable iff (rst_i)
    (gnt_fire & ~stale_q & ~redirect_i) |-> (!tag_full || rv_keep));
  a_tag_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    tag_cnt <= out_q);
  a_ent_room: assert property (@(posedge clk_i) disable iff (rst_i)
    (rv_keep & ~redirect_i) |-> (!ent_full || (fetch_valid_o & fetch_ready_i)));

endmodule

// File: tb/tb_miriscv_fetch_unit.sv
module tb_miriscv_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o, fetch_pc_o;
  logic        fetch_ready_i = 1'b0;
  logic        fetch_busy_o;

  // second instance: wrap-around boot address, always granted, always ready
  logic        w_req, w_valid, w_busy;
  logic [31:0] w_addr, w_instr, w_pc;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = '0;

  int   n_chk = 0, n_pass = 0;
  logic resp_en = 1'b0;
  logic [31:0] pend[$], glog[$], wlog[$], acc_pc[$], acc_instr[$];

  always #5 clk = ~clk;

  miriscv_fetch_unit u_dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o), .fetch_pc_o(fetch_pc_o),
    .fetch_ready_i(fetch_ready_i), .fetch_busy_o(fetch_busy_o)
  );

  miriscv_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
    .clk_i(clk), .rst_i(rst),
    .instr_req_o(w_req), .instr_addr_o(w_addr), .instr_gnt_i(1'b1),
    .instr_rvalid_i(w_rvalid), .instr_rdata_i(w_rdata),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .fetch_valid_o(w_valid), .fetch_instr_o(w_instr), .fetch_pc_o(w_pc),
    .fetch_ready_i(1'b1), .fetch_busy_o(w_busy)
  );

  function automatic logic [31:0] mk(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_DEAD;
  endfunction

  // One clock: log grants/acceptances seen this cycle, then model the bus
  // (response one cycle after grant when resp_en) and end any redirect pulse.
  task automatic tick();
    logic f, wf;
    logic [31:0] a, wa;
    f  = instr_req_o & instr_gnt_i;
    a  = instr_addr_o;
    wf = w_req;
    wa = w_addr;
    if (fetch_valid_o && fetch_ready_i) begin
      acc_pc.push_back(fetch_pc_o);
      acc_instr.push_back(fetch_instr_o);
    end
    @(posedge clk); #1;
    if (f && !rst) begin pend.push_back(a); glog.push_back(a); end
    if (wf && !rst && wlog.size() < 4) wlog.push_back(wa);
    w_rvalid = wf && !rst;
    w_rdata  = mk(wa);
    if (resp_en && !rst && pend.size() > 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mk(pend.pop_front());
    end else begin
      instr_rvalid_i = 1'b0;
    end
    redirect_i = 1'b0;
  endtask

  task automatic clear_logs();
    glog.delete(); acc_pc.delete(); acc_instr.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_chk++; if (instr_req_o !== 1'b0) $display("FAIL reset_req got=%0h exp=0", instr_req_o); else n_pass++;
    n_chk++; if (instr_addr_o !== 32'h0) $display("FAIL reset_addr got=%08h exp=00000000", instr_addr_o); else n_pass++;
    n_chk++; if (fetch_valid_o !== 1'b0) $display("FAIL reset_valid got=%0h exp=0", fetch_valid_o); else n_pass++;
    n_chk++; if (fetch_instr_o !== 32'h0) $display("FAIL reset_instr got=%08h exp=0", fetch_instr_o); else n_pass++;
    n_chk++; if (fetch_pc_o !== 32'h0) $display("FAIL reset_pc got=%08h exp=0", fetch_pc_o); else n_pass++;
    n_chk++; if (fetch_busy_o !== 1'b0) $display("FAIL reset_busy got=%0h exp=0", fetch_busy_o); else n_pass++;
    n_chk++; if (w_addr !== 32'hFFFF_FFF8) $display("FAIL reset_wrap_addr got=%08h exp=fffffff8", w_addr); else n_pass++;
  endtask

  task automatic test_boot();
    clear_logs();
    instr_gnt_i = 1'b1; fetch_ready_i = 1'b1; resp_en = 1'b1;
    rst = 1'b0;
    tick();  // boot cycle: no request yet
    n_chk++; if (instr_req_o !== 1'b1) $display("FAIL boot_req got=%0h exp=1", instr_req_o); else n_pass++;
    n_chk++; if (instr_addr_o !== 32'h0) $display("FAIL boot_addr got=%08h exp=0", instr_addr_o); else n_pass++;
    tick(); tick();  // grant 0, then its response lands
    n_chk++; if (fetch_valid_o !== 1'b1) $display("FAIL boot_latency_valid got=%0h exp=1", fetch_valid_o); else n_pass++;
    n_chk++; if (fetch_pc_o !== 32'h0) $display("FAIL boot_first_pc got=%08h exp=0", fetch_pc_o); else n_pass++;
    n_chk++; if (fetch_instr_o !== mk(32'h0)) $display("FAIL boot_first_instr got=%08h exp=%08h", fetch_instr_o, mk(32'h0)); else n_pass++;
    n_chk++; if (fetch_busy_o !== 1'b1) $display("FAIL boot_busy got=%0h exp=1", fetch_busy_o); else n_pass++;
    repeat (10) tick();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (qget(glog, i) !== 32'(4 * i)) $display("FAIL boot_addr_seq[%0d] got=%08h exp=%08h", i, qget(glog, i), 32'(4 * i));
      else n_pass++;
    end
    n_chk++; if (qget(acc_pc, 0) !== 32'h0) $display("FAIL boot_pc0 got=%08h exp=0", qget(acc_pc, 0)); else n_pass++;
    n_chk++; if (qget(acc_pc, 1) !== 32'h4) $display("FAIL boot_pc1 got=%08h exp=4", qget(acc_pc, 1)); else n_pass++;
    n_chk++; if (qget(acc_instr, 1) !== mk(32'h4)) $display("FAIL boot_instr1 got=%08h exp=%08h", qget(acc_instr, 1), mk(32'h4)); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] a0;
    instr_gnt_i = 1'b0;
    repeat (8) tick();  // drain; one request left waiting for grant
    clear_logs();
    fetch_ready_i = 1'b0; instr_gnt_i = 1'b1;
    repeat (4) tick();
    a0 = qget(glog, 0);
    n_chk++; if (fetch_pc_o !== a0) $display("FAIL bp_pc_early got=%08h exp=%08h", fetch_pc_o, a0); else n_pass++;
    repeat (6) tick();
    n_chk++; if (glog.size() !== 2) $display("FAIL bp_grants got=%0d exp=2", glog.size()); else n_pass++;
    n_chk++; if (qget(glog, 1) !== a0 + 32'd4) $display("FAIL bp_addr1 got=%08h exp=%08h", qget(glog, 1), a0 + 32'd4); else n_pass++;
    n_chk++; if (instr_req_o !== 1'b0) $display("FAIL bp_req got=%0h exp=0", instr_req_o); else n_pass++;
    n_chk++; if (fetch_valid_o !== 1'b1) $display("FAIL bp_valid got=%0h exp=1", fetch_valid_o); else n_pass++;
    n_chk++; if (fetch_pc_o !== a0) $display("FAIL bp_pc_stable got=%08h exp=%08h", fetch_pc_o, a0); else n_pass++;
    n_chk++; if (fetch_instr_o !== mk(a0)) $display("FAIL bp_instr_stable got=%08h exp=%08h", fetch_instr_o, mk(a0)); else n_pass++;
    fetch_ready_i = 1'b1;
    repeat (6) tick();
    n_chk++; if (qget(acc_pc, 0) !== a0) $display("FAIL bp_order0 got=%08h exp=%08h", qget(acc_pc, 0), a0); else n_pass++;
    n_chk++; if (qget(acc_pc, 1) !== a0 + 32'd4) $display("FAIL bp_order1 got=%08h exp=%08h", qget(acc_pc, 1), a0 + 32'd4); else n_pass++;
  endtask

  task automatic test_redirect();
    resp_en = 1'b0;
    repeat (8) tick();
    n_chk++; if (pend.size() !== 2) $display("FAIL rd_outstanding got=%0d exp=2", pend.size()); else n_pass++;
    n_chk++; if (instr_req_o !== 1'b0) $display("FAIL rd_req_credit got=%0h exp=0", instr_req_o); else n_pass++;
    clear_logs();
    redirect_pc_i = 32'h0000_0103; redirect_i = 1'b1;  // low bits must be ignored
    tick();
    n_chk++; if (fetch_valid_o !== 1'b0) $display("FAIL rd_valid got=%0h exp=0", fetch_valid_o); else n_pass++;
    n_chk++; if (instr_req_o !== 1'b0) $display("FAIL rd_drain_req got=%0h exp=0", instr_req_o); else n_pass++;
    n_chk++; if (fetch_busy_o !== 1'b1) $display("FAIL rd_busy got=%0h exp=1", fetch_busy_o); else n_pass++;
    resp_en = 1'b1;
    repeat (10) tick();
    n_chk++; if (qget(glog, 0) !== 32'h100) $display("FAIL rd_next_addr got=%08h exp=00000100", qget(glog, 0)); else n_pass++;
    n_chk++; if (qget(acc_pc, 0) !== 32'h100) $display("FAIL rd_first_pc got=%08h exp=00000100", qget(acc_pc, 0)); else n_pass++;
    n_chk++; if (qget(acc_instr, 0) !== mk(32'h100)) $display("FAIL rd_first_instr got=%08h exp=%08h", qget(acc_instr, 0), mk(32'h100)); else n_pass++;
  endtask

  task automatic test_ungranted_redirect();
    fetch_ready_i = 1'b0;
    repeat (8) tick();  // buffer full, no request
    n_chk++; if (fetch_valid_o !== 1'b1) $display("FAIL ug_full_valid got=%0h exp=1", fetch_valid_o); else n_pass++;
    instr_gnt_i = 1'b0;
    redirect_pc_i = 32'h8; redirect_i = 1'b1;
    tick();
    n_chk++; if (fetch_valid_o !== 1'b0) $display("FAIL ug_flush got=%0h exp=0", fetch_valid_o); else n_pass++;
    fetch_ready_i = 1'b1;
    repeat (3) tick();
    n_chk++; if (instr_req_o !== 1'b1) $display("FAIL ug_req got=%0h exp=1", instr_req_o); else n_pass++;
    n_chk++; if (instr_addr_o !== 32'h8) $display("FAIL ug_addr got=%08h exp=8", instr_addr_o); else n_pass++;
    redirect_pc_i = 32'h40; redirect_i = 1'b1;
    tick();
    n_chk++; if (instr_req_o !== 1'b1) $display("FAIL ug_req_held got=%0h exp=1", instr_req_o); else n_pass++;
    n_chk++; if (instr_addr_o !== 32'h8) $display("FAIL ug_addr_held got=%08h exp=8", instr_addr_o); else n_pass++;
    repeat (2) tick();
    n_chk++; if (instr_addr_o !== 32'h8) $display("FAIL ug_addr_held2 got=%08h exp=8", instr_addr_o); else n_pass++;
    clear_logs();
    instr_gnt_i = 1'b1;
    repeat (10) tick();
    n_chk++; if (qget(glog, 0) !== 32'h8) $display("FAIL ug_grant0 got=%08h exp=8", qget(glog, 0)); else n_pass++;
    n_chk++; if (qget(glog, 1) !== 32'h40) $display("FAIL ug_grant1 got=%08h exp=40", qget(glog, 1)); else n_pass++;
    n_chk++; if (qget(acc_pc, 0) !== 32'h40) $display("FAIL ug_first_pc got=%08h exp=40", qget(acc_pc, 0)); else n_pass++;
  endtask

  task automatic test_wrap();
    n_chk++; if (qget(wlog, 0) !== 32'hFFFF_FFF8) $display("FAIL wrap_a0 got=%08h exp=fffffff8", qget(wlog, 0)); else n_pass++;
    n_chk++; if (qget(wlog, 1) !== 32'hFFFF_FFFC) $display("FAIL wrap_a1 got=%08h exp=fffffffc", qget(wlog, 1)); else n_pass++;
    n_chk++; if (qget(wlog, 2) !== 32'h0) $display("FAIL wrap_a2 got=%08h exp=0", qget(wlog, 2)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    resp_en = 1'b0;
    repeat (8) tick();
    n_chk++; if (pend.size() !== 2) $display("FAIL rm_outstanding got=%0d exp=2", pend.size()); else n_pass++;
    n_chk++; if (fetch_busy_o !== 1'b1) $display("FAIL rm_busy_before got=%0h exp=1", fetch_busy_o); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (instr_req_o !== 1'b0) $display("FAIL rm_req got=%0h exp=0", instr_req_o); else n_pass++;
    n_chk++; if (fetch_valid_o !== 1'b0) $display("FAIL rm_valid got=%0h exp=0", fetch_valid_o); else n_pass++;
    n_chk++; if (fetch_busy_o !== 1'b0) $display("FAIL rm_busy got=%0h exp=0", fetch_busy_o); else n_pass++;
    n_chk++; if (instr_addr_o !== 32'h0) $display("FAIL rm_addr got=%08h exp=0", instr_addr_o); else n_pass++;
    pend.delete(); instr_rvalid_i = 1'b0; resp_en = 1'b1;
    tick(); tick();
    clear_logs();
    rst = 1'b0;
    repeat (8) tick();
    n_chk++; if (qget(glog, 0) !== 32'h0) $display("FAIL rm_restart_addr got=%08h exp=0", qget(glog, 0)); else n_pass++;
    n_chk++; if (qget(acc_pc, 0) !== 32'h0) $display("FAIL rm_restart_pc got=%08h exp=0", qget(acc_pc, 0)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    test_redirect();
    test_ungranted_redirect();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
